set_tag_lookup: RTL



---
 rtl/set_tag_lookup.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/set_tag_lookup.sv
// ---------------------------------------------------------------------------
// set_tag_lookup
//
// Tag-lookup and replacement controller for a 4-way set-associative cache.
// It splits each 32-bit request address into tag and set index. It looks up
// the set's stored tags, valid bits and LRU ages, and resolves hit or miss.
// On a miss it selects a victim way and runs a fill handshake with the memory
// side. When the fill is acked it writes that set's tag, valid and LRU state.
// Data arrays live elsewhere and are steered by the returned way number.
//
// Parameters
//   TAG_W  tag width (address bits [31 -: TAG_W])
//   IDX_W  set index width (address bits [2 +: IDX_W]), 2^IDX_W sets
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   req_valid   lookup request
//   req_addr    request address; [1:0] are ignored
//   req_ready   controller can accept a request (registered)
//   flush       invalidate every line (honoured in IDLE only)
//   rsp_valid   one-cycle response strobe
//   rsp_hit     1 = hit, 0 = miss that has been filled
//   rsp_way     way that hit or was filled
//   rsp_index   set of the response
//   fill_req    miss fill request, held until fill_ack
//   fill_tag    tag to fetch
//   fill_index  set being filled
//   fill_way    victim way
//   fill_ack    memory side has delivered the line
//   hit_count   (SET_TAG_LOOKUP_STATS_EN only) saturating hit counter
//   miss_count  (SET_TAG_LOOKUP_STATS_EN only) saturating miss counter
//
// Optional feature: define SET_TAG_LOOKUP_STATS_EN to add the hit/miss
// counters. Without it the ports and counters do not exist.
// ---------------------------------------------------------------------------
module set_tag_lookup #(
  parameter int TAG_W = 25,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [31:0]      req_addr,
  output logic             req_ready,
  input  logic             flush,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [1:0]       rsp_way,
  output logic [IDX_W-1:0] rsp_index,
  output logic             fill_req,
  output logic [TAG_W-1:0] fill_tag,
  output logic [IDX_W-1:0] fill_index,
  output logic [1:0]       fill_way,
  input  logic             fill_ack
`ifdef SET_TAG_LOOKUP_STATS_EN
  ,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
`endif
);

  localparam int NSETS = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t r_state;

  // Per-set storage. Ages are packed two bits per way: way w at [2w +: 2].
  logic [TAG_W-1:0] r_tag   [NSETS][4];
  logic [3:0]       r_valid [NSETS];
  logic [7:0]       r_age   [NSETS];

  logic [TAG_W-1:0] r_tag_q;
  logic [IDX_W-1:0] r_idx_q;

  logic [3:0]       w_match;
  logic             w_any_hit;
  logic [1:0]       w_hit_way;
  logic [1:0]       w_victim;
  logic             w_found_inv;
  logic [TAG_W-1:0] w_req_tag;
  logic [IDX_W-1:0] w_req_idx;
  logic             w_unused_addr;

  assign w_req_tag     = req_addr[31 -: TAG_W];
  assign w_req_idx     = req_addr[2 +: IDX_W];
  // The byte offset plays no part in tag lookup.
  assign w_unused_addr = ^req_addr[1:0];

  // Touch one way of a set: that way becomes age 0 and every way younger
  // than its old age ages by one, so the set stays a permutation of 0..3.
  function automatic logic [7:0] lru_touch(input logic [7:0] ages,
                                           input logic [1:0] way);
    logic [7:0] res;
    logic [1:0] old_age;
    old_age = ages[{way, 1'b0} +: 2];
    res     = ages;
    for (int w = 0; w < 4; w++) begin
      if (2'(w) == way) begin
        res[2*w +: 2] = 2'd0;
      end else if (ages[2*w +: 2] < old_age) begin
        res[2*w +: 2] = ages[2*w +: 2] + 2'd1;
      end
    end
    return res;
  endfunction

  // Compare the registered tag against all four ways of the registered set.
  // Hit way resolves to the lowest matching way. The victim is the lowest
  // invalid way, otherwise the oldest (age 3) way.
  always_comb begin
    w_match     = '0;
    w_hit_way   = 2'd0;
    w_victim    = 2'd0;
    w_found_inv = 1'b0;
    for (int w = 0; w < 4; w++) begin
      w_match[w] = r_valid[r_idx_q][w] && (r_tag[r_idx_q][w] == r_tag_q);
    end
    for (int w = 3; w >= 0; w--) begin
      if (w_match[w]) begin
        w_hit_way = 2'(w);
      end
    end
    for (int w = 0; w < 4; w++) begin
      if (!w_found_inv && !r_valid[r_idx_q][w]) begin
        w_victim    = 2'(w);
        w_found_inv = 1'b1;
      end
    end
    if (!w_found_inv) begin
      for (int w = 0; w < 4; w++) begin
        if (r_age[r_idx_q][2*w +: 2] == 2'd3) begin
          w_victim = 2'(w);
        end
      end
    end
  end

  assign w_any_hit = |w_match;

  // Controller FSM, registered outputs, valid/LRU state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_way    <= 2'd0;
      rsp_index  <= '0;
      fill_req   <= 1'b0;
      fill_tag   <= '0;
      fill_index <= '0;
      fill_way   <= 2'd0;
      r_tag_q    <= '0;
      r_idx_q    <= '0;
      for (int s = 0; s < NSETS; s++) begin
        r_valid[s] <= 4'b0000;
        r_age[s]   <= 8'b11_10_01_00;
      end
    end else begin
      case (r_state)
        IDLE: begin
          req_ready <= 1'b1;
          // flush wins over a simultaneous request.
          if (flush) begin
            for (int s = 0; s < NSETS; s++) begin
              r_valid[s] <= 4'b0000;
            end
          end else if (req_valid && req_ready) begin
            r_tag_q   <= w_req_tag;
            r_idx_q   <= w_req_idx;
            req_ready <= 1'b0;
            r_state   <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (w_any_hit) begin
            rsp_valid        <= 1'b1;
            rsp_hit          <= 1'b1;
            rsp_way          <= w_hit_way;
            rsp_index        <= r_idx_q;
            r_age[r_idx_q]   <= lru_touch(r_age[r_idx_q], w_hit_way);
            r_state          <= RESP;
          end else begin
            fill_req   <= 1'b1;
            fill_tag   <= r_tag_q;
            fill_index <= r_idx_q;
            fill_way   <= w_victim;
            r_state    <= MISS;
          end
        end

        MISS: begin
          // fill_* stay frozen until the memory side acks.
          if (fill_ack) begin
            fill_req                       <= 1'b0;
            r_valid[fill_index][fill_way]  <= 1'b1;
            r_age[fill_index]              <= lru_touch(r_age[fill_index], fill_way);
            rsp_valid                      <= 1'b1;
            rsp_hit                        <= 1'b0;
            rsp_way                        <= fill_way;
            rsp_index                      <= fill_index;
            r_state                        <= RESP;
          end
        end

        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          r_state   <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Tag array has no reset; a reset during MISS must not write it.
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == MISS) && fill_ack) begin
      r_tag[fill_index][fill_way] <= fill_tag;
    end
  end

`ifdef SET_TAG_LOOKUP_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counted while the response is on the bus; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
    end else if (r_state == RESP) begin
      if (rsp_hit) begin
        hit_count <= sat_inc(hit_count);
      end else begin
        miss_count <= sat_inc(miss_count);
      end
    end
  end
`endif

endmodule
